// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared types, constants and the round-robin pick helper
// for the packet arbiter (axis_pkt_arbiter) and its skid buffer.
//
// Contents:
//   arb_state_e        - arbiter FSM states (IDLE, BUSY)
//   MAX_IN             - upper bound on the number of arbitrated inputs
//   DEFAULT_DATA_WIDTH - default tdata width
//   rr_next()          - round-robin pick, returns {found, index}
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int MAX_IN             = 8;
  localparam int DEFAULT_DATA_WIDTH = 64;

  // Scans upward from (last+1) mod num_in, wrapping, and returns
  // {1'b1, idx} for the first requester found, or all zeros when no
  // input requests. Only indices below num_in are ever considered.
  // The loop runs downward so the smallest offset wins the last write.
  function automatic logic [3:0] rr_next(input logic [MAX_IN-1:0] req,
                                         input logic [2:0]        last,
                                         input int                num_in);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = MAX_IN; k >= 1; k--) begin
      if (k <= num_in) begin
        idx = 3'((int'(last) + k) % num_in);
        if (req[idx]) res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// axis_pkt_arbiter_if: bundle of the NUM_IN-wide AXI4-Stream input side
// and the single AXI4-Stream output side of the packet arbiter.
//
// Handshake: on every stream a beat transfers on a rising clock edge
// where tvalid and tready are both high. A source holds tvalid and its
// payload stable until the beat transfers; tvalid never waits on tready.
//
// Modports:
//   slave  - the arbiter: consumes S_AXIS_*, produces M_AXIS_*
//   master - the surrounding traffic: produces S_AXIS_*, consumes M_AXIS_*
// Input i occupies S_AXIS_tdata[i*DATA_WIDTH +: DATA_WIDTH] and
// S_AXIS_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH].
interface axis_pkt_arbiter_if #(
  parameter int NUM_IN     = 2,
  parameter int DATA_WIDTH = axis_arb_pkg::DEFAULT_DATA_WIDTH,
  parameter int ID_WIDTH   = 3
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [NUM_IN*DATA_WIDTH-1:0] S_AXIS_tdata;
  logic [NUM_IN*KEEP_WIDTH-1:0] S_AXIS_tkeep;
  logic [NUM_IN-1:0]            S_AXIS_tlast;
  logic [NUM_IN-1:0]            S_AXIS_tvalid;
  logic [NUM_IN-1:0]            S_AXIS_tready;

  logic [DATA_WIDTH-1:0]        M_AXIS_tdata;
  logic [KEEP_WIDTH-1:0]        M_AXIS_tkeep;
  logic                         M_AXIS_tlast;
  logic [ID_WIDTH-1:0]          M_AXIS_tid;
  logic                         M_AXIS_tvalid;
  logic                         M_AXIS_tready;

  modport slave (
    input  S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tlast, S_AXIS_tvalid, M_AXIS_tready,
    output S_AXIS_tready, M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast, M_AXIS_tid,
           M_AXIS_tvalid
  );

  modport master (
    output S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tlast, S_AXIS_tvalid, M_AXIS_tready,
    input  S_AXIS_tready, M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast, M_AXIS_tid,
           M_AXIS_tvalid
  );

endinterface

// File: rtl/axis_arb_skid.sv
// axis_arb_skid: two-entry skid buffer with fully registered outputs,
// used on the arbiter output when AXIS_ARB_OUT_REG_EN is defined.
//
// Ports:
//   i_clk, i_rst_n     - clock, asynchronous active-low reset (clears contents)
//   i_valid, o_ready   - upstream handshake (o_ready = buffer not full)
//   i_data             - upstream payload
//   o_valid, i_ready   - downstream handshake
//   o_data             - downstream payload (head entry)
module axis_arb_skid #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data0;  // head, drives o_data
  logic [WIDTH-1:0] r_data1;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_ready = (r_cnt != 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_data0;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data0 <= '0;
      r_data1 <= '0;
      r_cnt   <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_data0 <= i_data;
          else               r_data1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_cnt   <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Push while full cannot happen, so the count is 1 here.
          if (r_cnt == 2'd1) begin
            r_data0 <= i_data;
          end else begin
            r_data0 <= r_data1;
            r_data1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-granular round-robin arbiter merging NUM_IN
// AXI4-Stream inputs onto one output. A granted input owns the output
// until its tlast beat is accepted; the source index is sent on tid.
//
// Ports:
//   aclk, resetn  - clock, asynchronous active-low reset
//   bus           - axis_pkt_arbiter_if.slave (S_AXIS_* inputs, M_AXIS_* output)
//   grant_valid   - high while an input owns the output (registered)
//   grant_idx     - owning input; holds the last owner when idle
//   o_dbg_state   - current FSM state
//
// Build option: define AXIS_ARB_OUT_REG_EN to register all M_AXIS_*
// outputs through a two-entry skid buffer (+1 cycle latency).
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_IN     = 2,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ID_WIDTH   = 3
) (
  input  logic                 aclk,
  input  logic                 resetn,
  axis_pkt_arbiter_if.slave    bus,
  output logic                 grant_valid,
  output logic [ID_WIDTH-1:0]  grant_idx,
  output arb_state_e           o_dbg_state
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  arb_state_e            r_state, w_state_nxt;
  logic [2:0]            r_grant, w_grant_nxt;
  logic [2:0]            r_last,  w_last_nxt;
  logic [MAX_IN-1:0]     w_req;
  logic [3:0]            w_pick;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [KEEP_WIDTH-1:0] w_sel_keep;
  logic                  w_sel_last;
  logic                  w_sel_valid;
  logic                  w_busy;
  logic                  w_in_ready;
  logic                  w_take;
  logic                  w_done;

  assign w_req  = MAX_IN'(bus.S_AXIS_tvalid);
  assign w_pick = rr_next(w_req, r_last, NUM_IN);
  assign w_busy = (r_state == BUSY);

  // Granted-input mux
  always_comb begin
    w_sel_data  = '0;
    w_sel_keep  = '0;
    w_sel_last  = 1'b0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_grant == 3'(i)) begin
        w_sel_data  = bus.S_AXIS_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_keep  = bus.S_AXIS_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        w_sel_last  = bus.S_AXIS_tlast[i];
        w_sel_valid = bus.S_AXIS_tvalid[i];
      end
    end
  end

  // Only the granted input sees ready, and only while BUSY.
  always_comb begin
    bus.S_AXIS_tready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_busy && (r_grant == 3'(i))) bus.S_AXIS_tready[i] = w_in_ready;
    end
  end

  assign w_take = w_busy & w_sel_valid & w_in_ready;
  assign w_done = w_take & w_sel_last;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (w_pick[3]) begin
          w_state_nxt = BUSY;
          w_grant_nxt = w_pick[2:0];
        end
      end
      BUSY: begin
        if (w_done) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_grant;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // last_grant resets to NUM_IN-1 so input 0 has first priority.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_grant <= 3'd0;
      r_last  <= 3'(NUM_IN - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign grant_valid = w_busy;
  assign grant_idx   = ID_WIDTH'(r_grant);
  assign o_dbg_state = r_state;

`ifdef AXIS_ARB_OUT_REG_EN
  localparam int PW = ID_WIDTH + 1 + KEEP_WIDTH + DATA_WIDTH;

  logic [PW-1:0] w_skid_in;
  logic [PW-1:0] w_skid_out;
  logic          w_skid_ready;
  logic          w_skid_valid;

  assign w_skid_in = {ID_WIDTH'(r_grant), w_sel_last, w_sel_keep, w_sel_data};

  // The grant is released as soon as the tlast beat enters the buffer.
  axis_arb_skid #(.WIDTH(PW)) u_skid (
    .i_clk   (aclk),
    .i_rst_n (resetn),
    .i_valid (w_busy & w_sel_valid),
    .o_ready (w_skid_ready),
    .i_data  (w_skid_in),
    .o_valid (w_skid_valid),
    .i_ready (bus.M_AXIS_tready),
    .o_data  (w_skid_out)
  );

  assign w_in_ready        = w_skid_ready;
  assign bus.M_AXIS_tvalid = w_skid_valid;
  assign {bus.M_AXIS_tid, bus.M_AXIS_tlast, bus.M_AXIS_tkeep, bus.M_AXIS_tdata} = w_skid_out;
`else
  // Combinational path; outputs are forced to zero outside BUSY so a
  // reset drops them immediately.
  assign w_in_ready        = bus.M_AXIS_tready;
  assign bus.M_AXIS_tvalid = w_busy & w_sel_valid;
  assign bus.M_AXIS_tdata  = w_busy ? w_sel_data : '0;
  assign bus.M_AXIS_tkeep  = w_busy ? w_sel_keep : '0;
  assign bus.M_AXIS_tlast  = w_busy & w_sel_last;
  assign bus.M_AXIS_tid    = w_busy ? ID_WIDTH'(r_grant) : '0;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: self-checking bench for axis_pkt_arbiter.
// Expected output beats {tid, tlast, tkeep, tdata} are queued in arrival
// order when packets are staged and compared as the output hands them off.
// Works with and without AXIS_ARB_OUT_REG_EN.
module tb_axis_pkt_arbiter;
  import axis_arb_pkg::*;

  localparam int NUM_IN = 2;
  localparam int DW     = 64;
  localparam int IDW    = 3;
  localparam int EW     = IDW + 1 + 8 + DW;
`ifdef AXIS_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            aclk;
  logic            resetn;
  logic            grant_valid;
  logic [IDW-1:0]  grant_idx;
  arb_state_e      dbg_state;

  axis_pkt_arbiter_if #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) bus ();

  axis_pkt_arbiter #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) dut (
    .aclk        (aclk),
    .resetn      (resetn),
    .bus         (bus),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .o_dbg_state (dbg_state)
  );

  int             n_checks;
  int             n_fail;
  logic [EW-1:0]  exp_q[$];

  // ---------------- clock ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Beat k of packet pkt from input src: {tlast, tkeep, tdata}.
  function automatic logic [72:0] beat_of(input int src, input int pkt, input int k, input int n);
    logic [63:0] d;
    logic [7:0]  kp;
    logic        l;
    l = (k == n - 1);
    if (pkt == 99) begin
      case (k)
        0:       d = 64'hc40c02ca553e16fa;
        1:       d = 64'h0000007447c0887a;
        2:       d = 64'h0100000100030000;
        3:       d = 64'h0;
        default: d = 64'h5073930200000000;
      endcase
      kp = l ? 8'h0f : 8'hff;
    end else begin
      d  = {8'(src), 8'(pkt), 16'(k), 32'h5a5a_0000 ^ 32'(pkt * 131 + k * 17)};
      kp = l ? 8'(8'hff >> (pkt % 8)) : 8'hff;
    end
    return {l, kp, d};
  endfunction

  task automatic push_pkt(input int src, input int pkt, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({3'(src), beat_of(src, pkt, k, n)});
  endtask

  task automatic drive_beat(input int src, input logic [72:0] b);
    bus.S_AXIS_tdata[src*64 +: 64] = b[63:0];
    bus.S_AXIS_tkeep[src*8 +: 8]   = b[71:64];
    bus.S_AXIS_tlast[src]          = b[72];
    bus.S_AXIS_tvalid[src]         = 1'b1;
  endtask

  // Returns #1 after the edge that accepted the current beat of src.
  task automatic wait_accept(input int src, output bit ok);
    int t;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 300) begin
      @(negedge aclk);
      if (bus.S_AXIS_tready[src]) ok = 1'b1;
      @(posedge aclk);
      #1;
      t++;
    end
    if (!ok) check("accept_timeout", EW'(t), 0);
  endtask

  task automatic send_pkt(input int src, input int pkt, input int n, input int stall_at, input int stall_len);
    bit ok;
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        bus.S_AXIS_tvalid[src] = 1'b0;
        wait_cyc(stall_len);
      end
      drive_beat(src, beat_of(src, pkt, k, n));
      wait_accept(src, ok);
      if (!ok) break;
    end
    bus.S_AXIS_tvalid[src] = 1'b0;
    bus.S_AXIS_tlast[src]  = 1'b0;
  endtask

  // Counts negedges from now until the output first shows valid.
  task automatic first_lat_check(input string tag);
    int c;
    c = 0;
    @(negedge aclk);
    while (!bus.M_AXIS_tvalid && c < 20) begin
      c++;
      @(negedge aclk);
    end
    check(tag, EW'(c), EW'(LAT));
  endtask

  // Scoreboard side: every output handshake pops one expected beat.
  task automatic monitor();
    logic [EW-1:0] obs;
    forever begin
      @(negedge aclk);
      if (resetn && bus.M_AXIS_tvalid && bus.M_AXIS_tready) begin
        obs = {bus.M_AXIS_tid, bus.M_AXIS_tlast, bus.M_AXIS_tkeep, bus.M_AXIS_tdata};
        if (exp_q.size() == 0) check("beat_with_empty_queue", EW'(exp_q.size()), 1);
        else                   check("beat", obs, exp_q.pop_front());
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int t;
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    bus.S_AXIS_tdata  = '0;
    bus.S_AXIS_tkeep  = '0;
    bus.S_AXIS_tlast  = '0;
    bus.S_AXIS_tvalid = '0;
    bus.M_AXIS_tready = 1'b0;

    fork
      monitor();
      begin
        repeat (30000) @(posedge aclk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    wait_cyc(3);
    check("rst_m_tvalid", bus.M_AXIS_tvalid, 0);
    check("rst_m_tdata", bus.M_AXIS_tdata, 0);
    check("rst_s_tready", bus.S_AXIS_tready, 0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_idx", grant_idx, 0);
    check("rst_state", dbg_state, IDLE);

    // Contention from reset: both inputs continuously valid
    bus.M_AXIS_tready = 1'b1;
    push_pkt(0, 1, 3); push_pkt(1, 2, 3); push_pkt(0, 3, 3); push_pkt(1, 4, 3);
    resetn = 1'b1;
    fork
      begin send_pkt(0, 1, 3, -1, 0); send_pkt(0, 3, 3, -1, 0); end
      begin send_pkt(1, 2, 3, -1, 0); send_pkt(1, 4, 3, -1, 0); end
      first_lat_check("cont_first_latency");
    join
    wait_cyc(2);

    // Contention again under random downstream ready
    push_pkt(0, 5, 3); push_pkt(1, 6, 3); push_pkt(0, 7, 3); push_pkt(1, 8, 3);
    fork
      begin send_pkt(0, 5, 3, -1, 0); send_pkt(0, 7, 3, -1, 0); end
      begin send_pkt(1, 6, 3, -1, 0); send_pkt(1, 8, 3, -1, 0); end
      begin
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
          bus.M_AXIS_tready = 1'($urandom_range(0, 1));
          wait_cyc(1);
          t++;
        end
        bus.M_AXIS_tready = 1'b1;
      end
    join
    wait_cyc(2);

    // Single source, reference frame
    push_pkt(0, 99, 5);
    fork
      send_pkt(0, 99, 5, -1, 0);
      first_lat_check("single_first_latency");
    join
    wait_cyc(2);

    // Backpressure: downstream ready toggles every cycle
    push_pkt(0, 20, 4);
    fork
      send_pkt(0, 20, 4, -1, 0);
      begin
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
          @(negedge aclk);
`ifndef AXIS_ARB_OUT_REG_EN
          if (grant_valid) check("bp_ready_mirror", bus.S_AXIS_tready[0], bus.M_AXIS_tready);
`endif
          @(posedge aclk);
          #1;
          bus.M_AXIS_tready = ~bus.M_AXIS_tready;
          t++;
        end
        bus.M_AXIS_tready = 1'b1;
      end
    join
    wait_cyc(2);

    // Source stall: input 1 drops valid for 6 cycles while input 0 waits
    push_pkt(1, 30, 4); push_pkt(0, 31, 2);
    fork
      send_pkt(1, 30, 4, 2, 6);
      begin wait_cyc(3); send_pkt(0, 31, 2, -1, 0); end
      begin
        wait_cyc(6);
        check("stall_grant_valid", grant_valid, 1);
        check("stall_grant_idx", grant_idx, 1);
        check("stall_in0_not_ready", bus.S_AXIS_tready[0], 0);
        check("stall_out_idle", bus.M_AXIS_tvalid, 0);
      end
    join
    wait_cyc(2);

    // Reset pulsed on beat 2 of a packet from input 0
`ifndef AXIS_ARB_OUT_REG_EN
    exp_q.push_back({3'd0, beat_of(0, 40, 0, 3)});
`endif
    drive_beat(0, beat_of(0, 40, 0, 3));
    wait_accept(0, ok);
    drive_beat(0, beat_of(0, 40, 1, 3));
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_m_tvalid", bus.M_AXIS_tvalid, 0);
    check("mid_rst_m_tdata", bus.M_AXIS_tdata, 0);
    check("mid_rst_m_tlast", bus.M_AXIS_tlast, 0);
    check("mid_rst_m_tid", bus.M_AXIS_tid, 0);
    check("mid_rst_s_tready", bus.S_AXIS_tready, 0);
    check("mid_rst_grant_valid", grant_valid, 0);
    check("mid_rst_grant_idx", grant_idx, 0);
    bus.S_AXIS_tvalid[0] = 1'b0;
    bus.S_AXIS_tlast[0]  = 1'b0;
    wait_cyc(2);
    push_pkt(0, 41, 2); push_pkt(1, 42, 2);
    resetn = 1'b1;
    fork
      send_pkt(0, 41, 2, -1, 0);
      send_pkt(1, 42, 2, -1, 0);
      begin
        @(negedge aclk);
        @(negedge aclk);
        check("post_rst_grant_valid", grant_valid, 1);
        check("post_rst_grant_idx", grant_idx, 0);
      end
    join
    wait_cyc(3);

    check("exp_q_drained", EW'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-granular round-robin arbiter that merges NUM_IN 64-bit AXI4-Stream inputs onto one AXI4-Stream output. It is the sharing point in front of a single stream consumer: for example the network TX path, where several kernels' frames must be serialized onto one MAC/VIP stream port. Once granted, an input owns the output until its tlast beat is accepted, so frames are never interleaved. The output carries the source index on tid.

## Interface
Parameters:
- NUM_IN, 2: number of input streams, legal range 2..8.
- DATA_WIDTH, 64: tdata width; KEEP_WIDTH = DATA_WIDTH/8 (derived, not overridable).
- ID_WIDTH, 3: tid width; must satisfy 2**ID_WIDTH >= NUM_IN.

Ports:
- aclk  in  1  sole clock; all logic rising-edge.
- resetn  in  1  reset, asynchronous and active-low.
- S_AXIS_tdata  in  NUM_IN*DATA_WIDTH  input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- S_AXIS_tkeep  in  NUM_IN*KEEP_WIDTH  per-input byte enables.
- S_AXIS_tlast  in  NUM_IN  per-input end of packet.
- S_AXIS_tvalid  in  NUM_IN  per-input valid.
- S_AXIS_tready  out  NUM_IN  per-input ready.
- M_AXIS_tdata  out  DATA_WIDTH  merged data.
- M_AXIS_tkeep  out  KEEP_WIDTH  merged keep.
- M_AXIS_tlast  out  1  merged last.
- M_AXIS_tid  out  ID_WIDTH  index of the source input.
- M_AXIS_tvalid  out  1  merged valid.
- M_AXIS_tready  in  1  downstream ready.
- grant_valid  out  1  high while an input owns the output.
- grant_idx  out  ID_WIDTH  owning input; holds the last owner when idle.

## Operation
- States: IDLE and BUSY.
- IDLE:
  - All S_AXIS_tready are 0 and M_AXIS_tvalid is 0.
  - If any S_AXIS_tvalid is high, select the first asserted index scanning upward from (last_grant+1) mod NUM_IN, wrapping.
  - Register that index as the grant and move to BUSY.
- BUSY with grant g:
  - M_AXIS_* carry input g's signals, and M_AXIS_tid = g.
  - S_AXIS_tready[g] = M_AXIS_tready; all other S_AXIS_tready are 0.
  - A beat transfers when M_AXIS_tvalid and M_AXIS_tready are both high.
  - When a transferred beat has tlast=1: last_grant <= g, go to IDLE.
- While BUSY, tvalid on non-granted inputs has no effect.
- Input g dropping tvalid mid-packet stalls the output. There is no timeout and the grant is held.
- tkeep passes through unmodified. The arbiter neither checks nor alters its contents.
- A single-beat packet (tlast on the first beat) is legal and takes one BUSY cycle.
- Only NUM_IN inputs are scanned. Indices >= NUM_IN never win.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, last_grant=NUM_IN-1 (input 0 has first priority), grant_valid=0, grant_idx=0, M_AXIS_tvalid=0, all S_AXIS_tready=0.
- Arbitration costs exactly one cycle per packet. Maximum throughput for back-to-back packets is N beats per N+1 cycles.
- Without the register option, input-to-output latency in BUSY is 0 cycles (combinational mux).
- grant_valid equals (state==BUSY) and is registered.
- Simultaneous requests in IDLE are resolved by round-robin order only.
- A tlast beat accepted in cycle t puts the block in IDLE at t+1. It can re-enter BUSY at t+2 (possibly with the same input, if it is the only requester).
- Reset asserted mid-packet aborts the packet immediately. Downstream sees a truncated frame; this is accepted and documented behaviour.

## Configuration
- AXIS_ARB_OUT_REG_EN defined:
  - A two-entry skid buffer is inserted on the M_AXIS side, so all M_AXIS_* outputs are registered.
  - The granted S_AXIS_tready is driven by buffer-not-full instead of M_AXIS_tready.
  - Latency becomes +1 cycle; full throughput is kept within a packet.
  - The grant is released when the tlast beat enters the buffer.
  - Buffer contents are cleared on reset.
- AXIS_ARB_OUT_REG_EN undefined: the combinational path described above, with no buffer.

## Structure
- A shared package axis_arb_pkg holds:
  - the state typedef (IDLE, BUSY);
  - constants MAX_IN=8 and DEFAULT_DATA_WIDTH=64;
  - the round-robin next-index function.
- One sub-module, axis_arb_skid: the two-entry skid buffer, instantiated only under AXIS_ARB_OUT_REG_EN.

## Test plan
- Single source:
  - Stimulus: input 0 sends a 5-beat frame c40c02ca553e16fa, 0000007447c0887a, 0100000100030000, 0, 5073930200000000 with keep ff,ff,ff,ff,0f and tlast on beat 5.
  - Required: identical output, tid=0, one idle cycle before beat 1.
- Contention:
  - Stimulus: inputs 0 and 1 both hold 3-beat packets continuously valid from reset.
  - Required: output order is pkt0, pkt1, pkt0, pkt1. No interleaving inside a packet. tid matches the source.
- Backpressure:
  - Stimulus: M_AXIS_tready toggled 1010… during a 4-beat packet.
  - Required: no beat is dropped or duplicated, and S_AXIS_tready[g] mirrors M_AXIS_tready.
- Source stall:
  - Stimulus: input 1 drops tvalid for 6 cycles mid-packet while input 0 is valid.
  - Required: grant stays at 1, input 0 is not served until input 1's tlast is accepted.
- Reset mid-packet:
  - Stimulus: resetn pulsed low on beat 2.
  - Required: all outputs are 0 asynchronously, and input 0 wins first after release.
- With AXIS_ARB_OUT_REG_EN:
  - Stimulus: repeat the contention test.
  - Required: same output order, first beat one cycle later, and no beat loss under random M_AXIS_tready.
